// File: rtl/scoring_pkg.sv
// Shared types and helpers for the scoring round controller.
package scoring_pkg;

  // Round sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitDone,
    StTally,
    StReport
  } ctrl_state_e;

  // One 2-bit entry of the scoring matrix.
  typedef logic [1:0] score_entry_t;

  // Width needed for a row tally: the largest sum is 3*(n-1).
  function automatic int unsigned score_width(input int unsigned n);
    return $clog2(3 * n + 1);
  endfunction

endpackage

// File: rtl/scoring_row_tally.sv
// Combinational row tally: sums one matrix row, skipping the diagonal entry.
module scoring_row_tally
  import scoring_pkg::*;
#(
  parameter int unsigned N       = 10,
  parameter int unsigned SCORE_W = score_width(N),
  parameter int unsigned IDX_W   = $clog2(N)
) (
  input  logic [N*2-1:0]     row_vec,
  input  logic [IDX_W-1:0]   row_idx,
  output logic [SCORE_W-1:0] row_sum
);

  score_entry_t entry;

  // Accumulate every entry except the row's comparison against itself.
  always_comb begin
    row_sum = '0;
    entry   = '0;
    for (int unsigned c = 0; c < N; c++) begin
      entry = row_vec[2*c +: 2];
      if (IDX_W'(c) != row_idx) begin
        row_sum = row_sum + SCORE_W'(entry);
      end
    end
  end

endmodule

// File: rtl/scoring_round_ctrl.sv
// Round sequencer for the N x N 2-bit scoring matrix: loads N columns as one-hot
// writes, waits for the matrix done flag, tallies rows and reports the winner.
// Optional: define SCORING_CTRL_TIMEOUT_EN to add a WAIT_DONE watchdog and the
// timeout_err output.
module scoring_round_ctrl
  import scoring_pkg::*;
#(
  parameter int unsigned N       = 10,
  parameter int unsigned SCORE_W = score_width(N),
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 col_valid,
  output logic                 col_ready,
  input  logic [N*2-1:0]       col_data,
  output logic [N*2-1:0]       mat_data_in,
  output logic [N-1:0]         mat_data_valid,
  input  logic                 mat_done,
  input  logic [N*N*2-1:0]     matrix_in,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [$clog2(N)-1:0] winner_idx,
  output logic [SCORE_W-1:0]   winner_score,
`ifdef SCORING_CTRL_TIMEOUT_EN
  output logic                 timeout_err,
`endif
  output logic                 busy
);

  localparam int unsigned     IdxW    = $clog2(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  localparam logic [N-1:0]    SelCol0 = N'(1);

  if (N < 2 || TIMEOUT < 1) begin : g_param_check
    $error("scoring_round_ctrl: N must be >= 2 and TIMEOUT >= 1");
  end

  ctrl_state_e          state_q, state_d;
  logic [IdxW-1:0]      col_cnt_q, col_cnt_d;
  logic [IdxW-1:0]      row_cnt_q, row_cnt_d;
  logic [SCORE_W-1:0]   best_score_q, best_score_d;
  logic [IdxW-1:0]      best_idx_q, best_idx_d;
  logic [N*2-1:0]       mat_data_in_q, mat_data_in_d;
  logic [N-1:0]         mat_data_valid_q, mat_data_valid_d;

`ifdef SCORING_CTRL_TIMEOUT_EN
  localparam int unsigned TimeoutW = $clog2(TIMEOUT + 1);
  logic [TimeoutW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Split the flat matrix into rows so the tally can be muxed by the row counter.
  logic [N*2-1:0]     rows [N];
  logic [N*2-1:0]     row_vec;
  logic [SCORE_W-1:0] row_sum;

  for (genvar r = 0; r < N; r++) begin : g_rows
    assign rows[r] = matrix_in[r*N*2 +: N*2];
  end

  assign row_vec = rows[row_cnt_q];

  scoring_row_tally #(
    .N       (N),
    .SCORE_W (SCORE_W),
    .IDX_W   (IdxW)
  ) u_row_tally (
    .row_vec (row_vec),
    .row_idx (row_cnt_q),
    .row_sum (row_sum)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d          = state_q;
    col_cnt_d        = col_cnt_q;
    row_cnt_d        = row_cnt_q;
    best_score_d     = best_score_q;
    best_idx_d       = best_idx_q;
    mat_data_in_d    = mat_data_in_q;
    mat_data_valid_d = '0;
    col_ready        = 1'b0;
    result_valid     = 1'b0;
`ifdef SCORING_CTRL_TIMEOUT_EN
    wait_cnt_d       = '0;
    timeout_err      = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          col_cnt_d = '0;
        end
      end
      StLoad: begin
        col_ready = 1'b1;
        if (col_valid) begin
          mat_data_valid_d = SelCol0 << col_cnt_q;
          mat_data_in_d    = col_data;
          if (col_cnt_q == LastIdx) begin
            col_cnt_d = '0;
            state_d   = StWaitDone;
          end else begin
            col_cnt_d = col_cnt_q + IdxW'(1);
          end
        end
      end
      StWaitDone: begin
        // A done seen while the last write is still in flight belongs to the old round.
        if (mat_data_valid_q == '0 && mat_done) begin
          state_d   = StTally;
          row_cnt_d = '0;
        end
`ifdef SCORING_CTRL_TIMEOUT_EN
        else if (wait_cnt_q == TimeoutW'(TIMEOUT)) begin
          timeout_err = 1'b1;
          state_d     = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + TimeoutW'(1);
        end
`endif
      end
      StTally: begin
        // Strict greater-than keeps the lowest index on ties.
        if (row_cnt_q == '0 || row_sum > best_score_q) begin
          best_score_d = row_sum;
          best_idx_d   = row_cnt_q;
        end
        if (row_cnt_q == LastIdx) begin
          row_cnt_d = '0;
          state_d   = StReport;
        end else begin
          row_cnt_d = row_cnt_q + IdxW'(1);
        end
      end
      StReport: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any round in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      col_cnt_q        <= '0;
      row_cnt_q        <= '0;
      best_score_q     <= '0;
      best_idx_q       <= '0;
      mat_data_in_q    <= '0;
      mat_data_valid_q <= '0;
    end else begin
      state_q          <= state_d;
      col_cnt_q        <= col_cnt_d;
      row_cnt_q        <= row_cnt_d;
      best_score_q     <= best_score_d;
      best_idx_q       <= best_idx_d;
      mat_data_in_q    <= mat_data_in_d;
      mat_data_valid_q <= mat_data_valid_d;
    end
  end

`ifdef SCORING_CTRL_TIMEOUT_EN
  // Watchdog counter, cleared whenever the controller is outside WAIT_DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign mat_data_in    = mat_data_in_q;
  assign mat_data_valid = mat_data_valid_q;
  assign winner_idx     = best_idx_q;
  assign winner_score   = best_score_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_scoring_round_ctrl.sv
// Scoreboard bench for scoring_round_ctrl (N=4). Honours SCORING_CTRL_TIMEOUT_EN.
module tb_scoring_round_ctrl;
  import scoring_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = score_width(N);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned TO = 8;
  localparam int unsigned MW = 2 * N * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          col_valid = 1'b0;
  logic          col_ready;
  logic [2*N-1:0] col_data = '0;
  logic [2*N-1:0] mat_data_in;
  logic [N-1:0]  mat_data_valid;
  logic          mat_done = 1'b0;
  logic [MW-1:0] matrix_in = '0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [IW-1:0] winner_idx;
  logic [SW-1:0] winner_score;
  logic          busy;
`ifdef SCORING_CTRL_TIMEOUT_EN
  logic          timeout_err;
`endif

  scoring_round_ctrl #(
    .N       (N),
    .SCORE_W (SW),
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .col_valid      (col_valid),
    .col_ready      (col_ready),
    .col_data       (col_data),
    .mat_data_in    (mat_data_in),
    .mat_data_valid (mat_data_valid),
    .mat_done       (mat_done),
    .matrix_in      (matrix_in),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .winner_idx     (winner_idx),
    .winner_score   (winner_score),
`ifdef SCORING_CTRL_TIMEOUT_EN
    .timeout_err    (timeout_err),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [N-1:0]   sel;
    logic [2*N-1:0] data;
  } wr_t;

  typedef struct {
    int            cyc;
    logic [IW-1:0] idx;
    logic [SW-1:0] score;
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: per-row sum of off-diagonal entries, first maximum wins.
  function automatic void ref_winner(input logic [MW-1:0] m, output int idx, output int best);
    int s;
    best = -1;
    idx  = 0;
    for (int r = 0; r < N; r++) begin
      s = 0;
      for (int c = 0; c < N; c++) begin
        if (c != r) s += int'(m[(r*N+c)*2 +: 2]);
      end
      if (s > best) begin
        best = s;
        idx  = r;
      end
    end
  endfunction

  function automatic logic [2*N-1:0] col_of(input logic [MW-1:0] m, input int c);
    logic [2*N-1:0] d;
    for (int r = 0; r < N; r++) d[2*r +: 2] = m[(r*N+c)*2 +: 2];
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one column; record the expected write one cycle after the handshake.
  task automatic send_col(input int c, input logic [2*N-1:0] d, output int hs);
    int           guard;
    wr_t          w;
    logic [N-1:0] sel;
    guard     = 0;
    hs        = -1;
    col_valid = 1'b1;
    col_data  = d;
    while (col_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    if (col_ready !== 1'b1) begin
      check("col_ready_wait", col_ready, 1);
      return;
    end
    sel    = 1;
    w.cyc  = cyc + 1;
    w.sel  = sel << c;
    w.data = d;
    wr_q.push_back(w);
    hs = cyc;
    step();
  endtask

  // done_dly = 0: done already high (stale); otherwise done rises done_dly cycles
  // after the last handshake.
  task automatic run_round(input logic [MW-1:0] m, input int done_dly, input int stall,
                           input bit gaps);
    int   hs, idx, best, guard, eff;
    res_t rr;
    check("idle_before_start", busy, 0);
    matrix_in = m;
    mat_done  = (done_dly == 0);
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        col_valid = 1'b0;
        col_data  = 2*N'($urandom);
        repeat ($urandom_range(1, 3)) step();
      end
      send_col(c, col_of(m, c), hs);
      if (hs < 0) return;
    end
    col_valid = 1'b0;
    ref_winner(m, idx, best);
    eff      = (done_dly > 2) ? done_dly : 2;
    rr.cyc   = hs + eff + 1 + N;
    rr.idx   = IW'(idx);
    rr.score = SW'(best);
    res_q.push_back(rr);
    if (done_dly > 0) begin
      while (cyc < hs + done_dly) step();
      mat_done = 1'b1;
    end
    guard = 0;
    while (result_valid !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    if (result_valid !== 1'b1) begin
      check("result_wait", result_valid, 1);
      return;
    end
    repeat (stall) step();
    result_ready = 1'b1;
    start        = 1'($urandom_range(0, 1));
    step();
    result_ready = 1'b0;
    start        = 1'b0;
    check("idle_after_report", busy, 0);
    step();
    check("stay_idle", busy, 0);
    mat_done = 1'b0;
  endtask

  task automatic reset_mid_load(input logic [MW-1:0] m);
    int hs;
    matrix_in = m;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 2; c++) send_col(c, col_of(m, c), hs);
    col_valid = 1'b1;
    col_data  = col_of(m, 2);
    rst       = 1'b1;
    step();
    check("rst_col_ready", col_ready, 0);
    check("rst_mat_valid", mat_data_valid, 0);
    check("rst_mat_data", mat_data_in, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_winner_idx", winner_idx, 0);
    check("rst_winner_score", winner_score, 0);
    check("rst_busy", busy, 0);
    rst       = 1'b0;
    col_valid = 1'b0;
    step();
  endtask

`ifdef SCORING_CTRL_TIMEOUT_EN
  task automatic timeout_round(input logic [MW-1:0] m);
    int hs, guard, seen;
    matrix_in = m;
    mat_done  = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < N; c++) send_col(c, col_of(m, c), hs);
    col_valid = 1'b0;
    seen  = -1;
    guard = 0;
    while (seen < 0 && guard < 4 * TO) begin
      if (timeout_err === 1'b1) seen = cyc;
      else begin
        step();
        guard++;
      end
    end
    check("timeout_cycle", seen, hs + 1 + TO);
    step();
    check("timeout_busy", busy, 0);
    check("timeout_pulse_len", timeout_err, 0);
    check("timeout_no_result", result_valid, 0);
  endtask
`endif

  // Monitor: pops expected writes/results whenever the DUT presents them.
  wr_t  mw;
  res_t mr;
  bit   mon_en     = 1'b0;
  bit   res_seen   = 1'b0;
  bit   prev_stall = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (mat_data_valid !== '0) begin
        if (wr_q.size() == 0) check("unexpected_write", mat_data_valid, 0);
        else begin
          mw = wr_q.pop_front();
          check("write_cycle", cyc, mw.cyc);
          check("write_sel", mat_data_valid, mw.sel);
          check("write_data", mat_data_in, mw.data);
        end
      end
      if (prev_stall) check("result_held", result_valid, 1);
      if (result_valid === 1'b1) begin
        if (res_q.size() == 0) check("unexpected_result", result_valid, 0);
        else begin
          mr = res_q[0];
          if (!res_seen) check("result_latency", cyc, mr.cyc);
          res_seen = 1'b1;
          check("winner_idx", winner_idx, mr.idx);
          check("winner_score", winner_score, mr.score);
          if (result_ready === 1'b1) begin
            void'(res_q.pop_front());
            res_seen = 1'b0;
          end
        end
      end
      prev_stall = (result_valid === 1'b1) && (result_ready !== 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [MW-1:0] m;
    step();
    step();
    check("reset_col_ready", col_ready, 0);
    check("reset_mat_valid", mat_data_valid, 0);
    check("reset_mat_data", mat_data_in, 0);
    check("reset_result_valid", result_valid, 0);
    check("reset_winner_idx", winner_idx, 0);
    check("reset_winner_score", winner_score, 0);
    check("reset_busy", busy, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    // Row 2 dominates with 9; back-to-back columns; 5-cycle consumer stall.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[(r*N+c)*2 +: 2] = (r == 2) ? 2'd3 : 2'd1;
    run_round(m, 2, 5, 1'b0);

    reset_mid_load(m);

    // Rows 1 and 3 tie on 6; the lower index must win. Done raised while the
    // final write is still visible.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[(r*N+c)*2 +: 2] = (r == 1 || r == 3) ? 2'd2 : 2'd1;
    run_round(m, 1, 0, 1'b0);

    // Done held high from before the round starts.
    for (int i = 0; i < N * N; i++) m[2*i +: 2] = 2'($urandom_range(0, 3));
    run_round(m, 0, 1, 1'b0);

    repeat (20) begin
      for (int i = 0; i < N * N; i++) m[2*i +: 2] = 2'($urandom_range(0, 3));
      run_round(m, $urandom_range(0, 5), $urandom_range(0, 3), 1'b1);
    end

`ifdef SCORING_CTRL_TIMEOUT_EN
    timeout_round(m);
`endif

    repeat (3) step();
    check("writes_drained", wr_q.size(), 0);
    check("results_drained", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/scoring_round_ctrl.md
Name: scoring_round_ctrl

Overview:
Round sequencer for the N x N 2-bit scoring matrix. It accepts N score columns from an upstream producer over a valid/ready handshake and drives them into the matrix as one-hot column writes. It waits for the matrix's done flag, then tallies each row's score one row per cycle and reports the highest-scoring index to the downstream consumer. It sits between the comparison engine and the result/readout logic.

Parameters:
N, 10, number of rows/columns; must be >= 2.
SCORE_W, $clog2(3*N+1), width of a row tally; covers the max sum 3*(N-1).
TIMEOUT, 64, WAIT_DONE watchdog limit in cycles; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a round; sampled only in IDLE
col_valid  in  1  upstream column available
col_ready  out  1  controller accepts a column (high only in LOAD)
col_data  in  N*2  column entries, row r at bits [2r+1:2r]
mat_data_in  out  N*2  column data to the matrix (registered)
mat_data_valid  out  N  one-hot column select to the matrix (registered); zero = no write
mat_done  in  1  matrix done flag
matrix_in  in  N*N*2  matrix contents, entry [r][c]
result_valid  out  1  winner available
result_ready  in  1  downstream consumes the result
winner_idx  out  $clog2(N)  winning row
winner_score  out  SCORE_W  winning row's tally
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; col counter = 0; row counter = 0; best score/index = 0.
- Reset output values: col_ready=0, mat_data_valid=0, mat_data_in=0, result_valid=0, winner_idx=0, winner_score=0, busy=0.
- Reset mid-round aborts the round immediately. No partial write is issued after reset.
- FSM states: IDLE, LOAD, WAIT_DONE, TALLY, REPORT.
- IDLE -> LOAD when start=1. start in any other state is ignored.
- LOAD:
  - col_ready=1.
  - On a handshake at column c: next cycle mat_data_valid = 1<<c for exactly one cycle, and mat_data_in = col_data. Then c increments.
  - Columns are written strictly in order 0..N-1.
  - The handshake for column N-1 moves the FSM to WAIT_DONE. col_ready drops in the same cycle as the transition.
- WAIT_DONE:
  - mat_done is ignored while mat_data_valid != 0, so a stale done from the previous round is never taken as fresh.
  - Otherwise, mat_done=1 -> TALLY with row = 0.
  - Nominally done is seen 2 cycles after the last handshake.
- TALLY: one row per cycle, N cycles total.
  - score(r) = sum over c != r of matrix_in[r][c]. The diagonal is excluded. Zero-extend to SCORE_W; no overflow is possible.
  - Track best: replace only if score > best. Ties keep the lower index. Row 0 initialises best.
  - After row N-1 -> REPORT.
- REPORT:
  - result_valid=1, with winner_idx/winner_score held stable until result_ready=1.
  - Handshake -> IDLE and result_valid drops.
  - start asserted in the same cycle as that handshake is ignored; a new start is taken in IDLE.
- Latency from the last column handshake to result_valid: 2 + N + 1 cycles, when done arrives promptly.
- col_valid with col_ready=0 is simply not accepted. There is no buffering.

Optional Feature:
SCORING_CTRL_TIMEOUT_EN.
- Defined:
  - Adds a WAIT_DONE cycle counter and an output port `timeout_err` (1 bit, reset 0).
  - If TIMEOUT cycles elapse in WAIT_DONE without a valid mat_done: timeout_err pulses for 1 cycle and the FSM returns to IDLE without reporting.
- Undefined: WAIT_DONE waits indefinitely; no port and no counter.

Decomposition:
- Package scoring_pkg:
  - ctrl_state_e enum (IDLE, LOAD, WAIT_DONE, TALLY, REPORT).
  - Function for score width ($clog2(3*N+1)).
  - Type for a 2-bit score entry.
- Natural sub-module: scoring_row_tally. Purely combinational: row vector plus row index -> diagonal-excluded sum. Instantiated once and muxed by the row counter.

Test Plan:
- N=4, start, 4 back-to-back columns with col_valid held -> mat_data_valid sequence 0001, 0010, 0100, 1000 on consecutive cycles, each lagging its handshake by 1 cycle.
- N=4, row 2 = {3,3,_,3} and all other rows 1s -> TALLY yields 9 for row 2; winner_idx=2, winner_score=9; result_valid held while result_ready=0 for 5 cycles.
- Tie: rows 1 and 3 both score 6, all others lower -> winner_idx=1.
- Stale done: matrix done held high from the previous round, N=2, columns sent -> no transition until mat_data_valid returns to 0; TALLY starts only after that.
- rst pulsed mid-LOAD after 2 columns -> next cycle all outputs at reset values; a fresh start rewrites from column 0.
- With SCORING_CTRL_TIMEOUT_EN, TIMEOUT=8, mat_done tied 0 -> timeout_err pulses 8 cycles after entering WAIT_DONE; busy=0 next cycle; no result_valid.
